// File: rtl/plab5_mcore_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : plab5_mcore_mem_req_arbiter
// Purpose  : Shares one memory request/response port between the icache
//            (port 0) and dcache (port 1) of a plab5 multicore tile. One
//            transaction is in flight at a time: the winning request is
//            latched, sent to memory, and the response is steered back to
//            the requester that owns it.
// Options  : PLAB5_MCORE_MEM_ARB_RR_EN - round-robin between simultaneous
//            requests; when undefined port 0 always wins ties.
// Revision : 1.0 - initial release
// ============================================================================
module plab5_mcore_mem_req_arbiter #(
   parameter int p_opaque_nbits = 8,
   parameter int p_addr_nbits   = 32,
   parameter int p_data_nbits   = 32,
   parameter int REQ_NBITS      = 3 + p_opaque_nbits + p_addr_nbits
                                  + $clog2(p_data_nbits/8) + p_data_nbits,
   parameter int RESP_NBITS     = 3 + p_opaque_nbits
                                  + $clog2(p_data_nbits/8) + p_data_nbits
)(
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  req0_val,
   output logic                  req0_rdy,
   input  logic [REQ_NBITS-1:0]  req0_msg,

   input  logic                  req1_val,
   output logic                  req1_rdy,
   input  logic [REQ_NBITS-1:0]  req1_msg,

   output logic                  memreq_val,
   input  logic                  memreq_rdy,
   output logic [REQ_NBITS-1:0]  memreq_msg,

   input  logic                  memresp_val,
   output logic                  memresp_rdy,
   input  logic [RESP_NBITS-1:0] memresp_msg,

   output logic                  resp0_val,
   input  logic                  resp0_rdy,
   output logic [RESP_NBITS-1:0] resp0_msg,

   output logic                  resp1_val,
   input  logic                  resp1_rdy,
   output logic [RESP_NBITS-1:0] resp1_msg,

   output logic                  grant_id
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic                   r_grant_id;
   logic [REQ_NBITS-1:0]   r_msg;
   logic                   w_prio;
   logic                   w_winner;
   logic                   w_accept;
   logic                   w_resp_done;

`ifdef PLAB5_MCORE_MEM_ARB_RR_EN
   logic                   r_prio;

   // Favour the port that was not served last once a response completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_prio <= 1'b0;
      else if (w_resp_done)
         r_prio <= ~r_grant_id;
   end

   assign w_prio = r_prio;
`else
   // Fixed priority: port 0 always wins a tie.
   assign w_prio = 1'b0;
`endif

   // A lone requester wins outright; a tie goes to the favoured port.
   assign w_winner = (req0_val && req1_val) ? w_prio : req1_val;

   // State register; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   // Capture the winning request and its owner when it is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_grant_id <= 1'b0;
         r_msg      <= '0;
      end else if (w_accept) begin
         r_grant_id <= w_winner;
         r_msg      <= w_winner ? req1_msg : req0_msg;
      end
   end

   // Next-state and handshake outputs for the current phase.
   always_comb begin
      w_state_next = r_state;
      req0_rdy     = 1'b0;
      req1_rdy     = 1'b0;
      memreq_val   = 1'b0;
      memresp_rdy  = 1'b0;
      resp0_val    = 1'b0;
      resp1_val    = 1'b0;
      w_accept     = 1'b0;
      w_resp_done  = 1'b0;

      case (r_state)
         IDLE: begin
            req0_rdy = req0_val && !w_winner;
            req1_rdy = req1_val &&  w_winner;
            w_accept = req0_val || req1_val;
            if (w_accept)
               w_state_next = SEND;
         end
         SEND: begin
            memreq_val = 1'b1;
            if (memreq_rdy)
               w_state_next = WAIT;
         end
         WAIT: begin
            if (r_grant_id) begin
               resp1_val   = memresp_val;
               memresp_rdy = resp1_rdy;
            end else begin
               resp0_val   = memresp_val;
               memresp_rdy = resp0_rdy;
            end
            w_resp_done = memresp_val && memresp_rdy;
            if (w_resp_done)
               w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Response payload goes to both ports; only the val bit selects the owner.
   assign memreq_msg = r_msg;
   assign resp0_msg  = memresp_msg;
   assign resp1_msg  = memresp_msg;
   assign grant_id   = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_plab5_mcore_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_plab5_mcore_mem_req_arbiter
// Purpose  : Self-checking bench for plab5_mcore_mem_req_arbiter. A table of
//            transactions is played through the arbiter; each accepted
//            request is queued and checked when it appears on the memory
//            port. Reset-during-WAIT is exercised by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_plab5_mcore_mem_req_arbiter;

   localparam int REQ_NBITS  = 77;
   localparam int RESP_NBITS = 45;
`ifdef PLAB5_MCORE_MEM_ARB_RR_EN
   localparam logic RR = 1'b1;
`else
   localparam logic RR = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  req0_val, req0_rdy;
   logic [REQ_NBITS-1:0]  req0_msg;
   logic                  req1_val, req1_rdy;
   logic [REQ_NBITS-1:0]  req1_msg;
   logic                  memreq_val, memreq_rdy;
   logic [REQ_NBITS-1:0]  memreq_msg;
   logic                  memresp_val, memresp_rdy;
   logic [RESP_NBITS-1:0] memresp_msg;
   logic                  resp0_val, resp0_rdy;
   logic [RESP_NBITS-1:0] resp0_msg;
   logic                  resp1_val, resp1_rdy;
   logic [RESP_NBITS-1:0] resp1_msg;
   logic                  grant_id;

   plab5_mcore_mem_req_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .req0_val    (req0_val),
      .req0_rdy    (req0_rdy),
      .req0_msg    (req0_msg),
      .req1_val    (req1_val),
      .req1_rdy    (req1_rdy),
      .req1_msg    (req1_msg),
      .memreq_val  (memreq_val),
      .memreq_rdy  (memreq_rdy),
      .memreq_msg  (memreq_msg),
      .memresp_val (memresp_val),
      .memresp_rdy (memresp_rdy),
      .memresp_msg (memresp_msg),
      .resp0_val   (resp0_val),
      .resp0_rdy   (resp0_rdy),
      .resp0_msg   (resp0_msg),
      .resp1_val   (resp1_val),
      .resp1_rdy   (resp1_rdy),
      .resp1_msg   (resp1_msg),
      .grant_id    (grant_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic                  r0v;
      logic                  r1v;
      logic [REQ_NBITS-1:0]  m0;
      logic [REQ_NBITS-1:0]  m1;
      logic                  g;
      int                    sstall;
      int                    rstall;
      logic [RESP_NBITS-1:0] resp;
   } vec_t;

   typedef struct {
      logic [REQ_NBITS-1:0] msg;
      logic                 g;
   } sb_t;

   vec_t vecs[8];
   sb_t  sb_q[$];
   int   nvec = 0;
   int   nerr = 0;

   function automatic logic [REQ_NBITS-1:0] mk_req(logic [2:0] t, logic [7:0] o,
                                                   logic [31:0] a, logic [31:0] d);
      return {t, o, a, 2'b00, d};
   endfunction

   function automatic logic [RESP_NBITS-1:0] mk_resp(logic [2:0] t, logic [7:0] o,
                                                     logic [31:0] d);
      return {t, o, 2'b00, d};
   endfunction

   function automatic vec_t mkv(logic r0v, logic r1v, logic [REQ_NBITS-1:0] m0,
                                logic [REQ_NBITS-1:0] m1, logic g, int ss, int rs,
                                logic [RESP_NBITS-1:0] resp);
      vec_t v;
      v.r0v = r0v; v.r1v = r1v; v.m0 = m0; v.m1 = m1; v.g = g;
      v.sstall = ss; v.rstall = rs; v.resp = resp;
      return v;
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(string name, logic act, logic exp);
      chk(name, 128'(act), 128'(exp));
   endtask

   // One full transaction: accept in IDLE, stall in SEND, stall in WAIT.
   task automatic run_txn(vec_t v);
      sb_t e;
      @(negedge clk);
      req0_val = v.r0v; req1_val = v.r1v;
      req0_msg = v.m0;  req1_msg = v.m1;
      #1;
      chk1("idle_req0_rdy", req0_rdy, !v.g);
      chk1("idle_req1_rdy", req1_rdy, v.g);
      chk1("idle_memreq_val", memreq_val, 1'b0);
      sb_q.push_back('{msg: (v.g ? v.m1 : v.m0), g: v.g});

      e = sb_q.pop_front();
      for (int k = 0; k <= v.sstall; k++) begin
         @(negedge clk);
         memreq_rdy  = (k == v.sstall);
         memresp_val = 1'b1;
         memresp_msg = v.resp;
         #1;
         chk1("send_memreq_val", memreq_val, 1'b1);
         chk("send_memreq_msg", 128'(memreq_msg), 128'(e.msg));
         chk1("send_grant_id", grant_id, e.g);
         chk1("send_req0_rdy", req0_rdy, 1'b0);
         chk1("send_req1_rdy", req1_rdy, 1'b0);
         chk1("send_memresp_rdy", memresp_rdy, 1'b0);
         chk1("send_resp_val", resp0_val | resp1_val, 1'b0);
      end

      for (int k = 0; k <= v.rstall; k++) begin
         @(negedge clk);
         req0_val   = 1'b0; req1_val = 1'b0;
         memreq_rdy = 1'b0;
         resp0_rdy  = e.g ? 1'b1 : (k == v.rstall);
         resp1_rdy  = e.g ? (k == v.rstall) : 1'b1;
         #1;
         chk1("wait_resp0_val", resp0_val, !e.g);
         chk1("wait_resp1_val", resp1_val, e.g);
         chk1("wait_memresp_rdy", memresp_rdy, (k == v.rstall));
         chk1("wait_memreq_val", memreq_val, 1'b0);
         chk("wait_resp0_msg", 128'(resp0_msg), 128'(v.resp));
         chk("wait_resp1_msg", 128'(resp1_msg), 128'(v.resp));
      end

      @(negedge clk);
      memresp_val = 1'b0; resp0_rdy = 1'b0; resp1_rdy = 1'b0;
      #1;
      chk1("done_memreq_val", memreq_val, 1'b0);
      chk1("done_resp_val", resp0_val | resp1_val, 1'b0);
      chk1("done_grant_hold", grant_id, e.g);
      chk1("done_req_rdy", req0_rdy | req1_rdy, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      req0_val = 1'b0; req1_val = 1'b0; req0_msg = '0; req1_msg = '0;
      memreq_rdy = 1'b0; memresp_val = 1'b0; memresp_msg = '0;
      resp0_rdy = 1'b0; resp1_rdy = 1'b0;

      //               r0v r1v m0                                     m1                                      g    ss rs resp
      vecs[0] = mkv(1, 0, mk_req(3'd1, 8'h01, 32'h1000, 32'hdeadbeef), '0,                                     1'b0, 0, 0, mk_resp(3'd1, 8'h01, 32'h0));
      vecs[1] = mkv(0, 1, '0,                                     mk_req(3'd0, 8'h12, 32'h2004, 32'h0),     1'b1, 0, 3, mk_resp(3'd0, 8'h12, 32'h0badf00d));
      vecs[2] = mkv(1, 1, mk_req(3'd0, 8'h21, 32'h3000, 32'h0),     mk_req(3'd1, 8'h22, 32'h4000, 32'h55aa55aa), 1'b0, 5, 0, mk_resp(3'd0, 8'h21, 32'h11111111));
      vecs[3] = mkv(1, 1, mk_req(3'd0, 8'h31, 32'h3010, 32'h0),     mk_req(3'd1, 8'h32, 32'h4010, 32'h12345678), RR,   1, 1, mk_resp(3'd1, 8'h32, 32'h22222222));
      vecs[4] = mkv(1, 1, mk_req(3'd1, 8'h41, 32'h3020, 32'hcafef00d), mk_req(3'd0, 8'h42, 32'h4020, 32'h0),  1'b0, 0, 2, mk_resp(3'd1, 8'h41, 32'h33333333));
      vecs[5] = mkv(1, 1, mk_req(3'd0, 8'h51, 32'h3030, 32'h0),     mk_req(3'd0, 8'h52, 32'h4030, 32'h0),     RR,   2, 0, mk_resp(3'd0, 8'h52, 32'h44444444));
      vecs[6] = mkv(0, 1, '0,                                     mk_req(3'd1, 8'h62, 32'h4040, 32'hfeedface), 1'b1, 0, 0, mk_resp(3'd1, 8'h62, 32'h55555555));
      vecs[7] = mkv(1, 0, mk_req(3'd0, 8'h71, 32'h3040, 32'h0),     '0,                                     1'b0, 1, 1, mk_resp(3'd0, 8'h71, 32'h66666666));

      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk1("rst_memreq_val", memreq_val, 1'b0);
      chk1("rst_memresp_rdy", memresp_rdy, 1'b0);
      chk1("rst_resp_val", resp0_val | resp1_val, 1'b0);
      chk1("rst_req_rdy", req0_rdy | req1_rdy, 1'b0);
      chk1("rst_grant_id", grant_id, 1'b0);
      chk("rst_memreq_msg", 128'(memreq_msg), 128'(0));

      for (int i = 0; i < 8; i++)
         run_txn(vecs[i]);

      // Bring a port-0 transaction into WAIT, then reset mid-cycle.
      @(negedge clk);
      req0_val = 1'b1; req0_msg = mk_req(3'd0, 8'h81, 32'h5000, 32'h0);
      @(negedge clk);
      req0_val = 1'b0; memreq_rdy = 1'b1;
      @(negedge clk);
      memreq_rdy = 1'b0; memresp_val = 1'b1; memresp_msg = mk_resp(3'd0, 8'h81, 32'h77);
      resp0_rdy = 1'b0;
      #1;
      chk1("prerst_resp0_val", resp0_val, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk1("arst_memreq_val", memreq_val, 1'b0);
      chk1("arst_resp_val", resp0_val | resp1_val, 1'b0);
      chk1("arst_memresp_rdy", memresp_rdy, 1'b0);
      chk1("arst_grant_id", grant_id, 1'b0);
      chk("arst_memreq_msg", 128'(memreq_msg), 128'(0));
      @(negedge clk);
      reset = 1'b0; memresp_val = 1'b0;

      run_txn(mkv(0, 1, '0, mk_req(3'd1, 8'h92, 32'h6000, 32'ha5a5a5a5), 1'b1, 0, 0,
                  mk_resp(3'd1, 8'h92, 32'h0)));

      chk("sb_empty", 128'(sb_q.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire
